regfile_param: RTL



---
 rtl/regfile_param.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with hardwired-zero option,
// clear sequencer (CLEAR/RUN), ready status and dropped-write flag.
// Optional write-to-read bypass on read ports 1 and 2: define REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            regWrite,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] writeData,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  input  logic [AW-1:0]   displaySelect,
  output logic [XLEN-1:0] displayData,
  input  logic            clear_req,
  output logic            ready,
  output logic            wr_drop
);

  localparam int NREGS   = 1 << AW;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   idx, idx_next;
  logic            drop_next;
  logic            rd_is_zero;
  logic            wr_ok;
  logic [XLEN-1:0] regs [NREGS];

  assign rd_is_zero = ZERO_EN && (rd == '0);
  // A write lands only in RUN and never on a hardwired-zero register 0.
  assign wr_ok      = regWrite && (state == RUN) && !rd_is_zero;

  // State register: sequencer state, clear index and dropped-write flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (!rst_n) begin
      state   <= CLEAR;
      idx     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      wr_drop <= drop_next;
    end
  end

  // Next-state logic: step through every register, then run until cleared.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    state_next = state;
    idx_next   = idx;
    drop_next  = regWrite && ((state == CLEAR) || rd_is_zero);
    unique case (state)
      CLEAR: begin
        idx_next = idx + AW'(1);
        if (idx == AW'(NREGS - 1)) state_next = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_next = CLEAR;
          idx_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Output logic: ready tracks the RUN state exactly.
  always_comb begin
    ready = (state == RUN);
  end

  // Storage update: zeroing by the sequencer, otherwise accepted writes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch on purpose; it is zeroed by the
    // sequencer, which keeps it mappable onto plain RAM/LUT storage.
    if (rst_n) begin
      if (state == CLEAR)
        regs[idx] <= '0;
      else if (wr_ok)
        regs[rd] <= writeData;
    end
  end

  // Read ports: zero while clearing, zero for hardwired register 0.
  always_comb begin
    readData1   = '0;
    readData2   = '0;
    displayData = '0;
    if (ready) begin
      if (!(ZERO_EN && rs1 == '0))           readData1   = regs[rs1];
      if (!(ZERO_EN && rs2 == '0))           readData2   = regs[rs2];
      if (!(ZERO_EN && displaySelect == '0)) displayData = regs[displaySelect];
`ifdef REGFILE_BYPASS_EN
      // Forward an accepted same-cycle write; the debug port sees stored data.
      if (wr_ok && rs1 == rd) readData1 = writeData;
      if (wr_ok && rs2 == rd) readData2 = writeData;
`endif
    end
  end

endmodule
